// File: rtl/mem_pkg.sv
// Shared definitions for the burst read responder: FSM state type and
// default geometry used when the block is instantiated without overrides.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int AN_DEF    = 24;
  localparam int DN_DEF    = 16;
  localparam int BURST_DEF = 8;

endpackage

// File: rtl/mem_burst_resp.sv
// Burst read responder: accepts a start address from a requester, issues
// BURST consecutive memory reads (honouring ram_wait), and forwards each
// returned word one cycle after it arrives. Only one burst is ever in flight;
// a new request is accepted only once every word of the previous burst has
// been handed back.
module mem_burst_resp
  import mem_pkg::*;
#(
  parameter int AN    = AN_DEF,
  parameter int DN    = DN_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic          clkSYS,
  input  logic          aclr,
  input  logic          request,
  input  logic [AN-1:0] req_addr,
  output logic          req_ack,
  output logic [DN-1:0] mem_data,
  output logic          mem_valid,
  output logic [AN-1:0] ram_addr,
  output logic          ram_rd,
  input  logic          ram_wait,
  input  logic [DN-1:0] ram_rdata,
  input  logic          ram_rvalid,
  output logic          busy,
  output logic          err
);

  // Counters need one extra bit so that the value BURST itself is representable.
  localparam int            CW       = $clog2(BURST) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BURST - 1);
  localparam logic [CW-1:0] BURST_N  = CW'(BURST);

  state_t        state;
  logic [CW-1:0] iss_cnt;
  logic [CW-1:0] ret_cnt;
  logic          rv_ok;

  // A return is legitimate only while reads are outstanding for this burst;
  // anything else is dropped and flagged.
  assign rv_ok = ram_rvalid && ((state == ISSUE) || (state == DRAIN)) && (ret_cnt != BURST_N);

  // Request/issue FSM: latches the start address, pulses req_ack, walks the
  // read address forward on every accepted read, then waits for all returns.
  always_ff @(posedge clkSYS or posedge aclr) begin
    if (aclr) begin
      state    <= IDLE;
      req_ack  <= 1'b0;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
      iss_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      req_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            ram_addr <= req_addr;
            req_ack  <= 1'b1;
            busy     <= 1'b1;
            state    <= ACK;
          end
        end
        ACK: begin
          iss_cnt <= '0;
          ram_rd  <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
          // ram_rd is held high for the whole of ISSUE, so a clear ram_wait
          // means the current address was taken this cycle.
          if (!ram_wait) begin
            iss_cnt <= iss_cnt + CW'(1);
            if (iss_cnt == LAST_IDX) begin
              ram_rd <= 1'b0;
              state  <= DRAIN;
            end else begin
              ram_addr <= ram_addr + AN'(1);
            end
          end
        end
        DRAIN: begin
          // ret_cnt reaches BURST in the same cycle the last mem_valid is
          // shown, so busy drops one cycle after that final word.
          if (ret_cnt == BURST_N) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path: register each legitimate return onto mem_data/mem_valid,
  // count returns for the current burst, and latch err on stray returns.
  always_ff @(posedge clkSYS or posedge aclr) begin
    if (aclr) begin
      mem_valid <= 1'b0;
      mem_data  <= '0;
      ret_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      mem_valid <= rv_ok;
      if (rv_ok) begin
        mem_data <= ram_rdata;
      end
      if (state == IDLE) begin
        ret_cnt <= '0;
      end else if (rv_ok) begin
        ret_cnt <= ret_cnt + CW'(1);
      end
      if (ram_rvalid && !rv_ok) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_resp.sv
// Bench for mem_burst_resp: a memory responder with programmable stall and
// latency, a request driver, and a monitor that checks every cycle against a
// transaction-level model (expected address/data queues, outstanding-read
// count, sticky error flag).
module tb_mem_burst_resp;

  localparam int AN    = 24;
  localparam int DN    = 16;
  localparam int BURST = 8;

  logic          clkSYS     = 1'b0;
  logic          aclr       = 1'b0;
  logic          request    = 1'b0;
  logic [AN-1:0] req_addr   = '0;
  logic          req_ack;
  logic [DN-1:0] mem_data;
  logic          mem_valid;
  logic [AN-1:0] ram_addr;
  logic          ram_rd;
  logic          ram_wait   = 1'b0;
  logic [DN-1:0] ram_rdata  = '0;
  logic          ram_rvalid = 1'b0;
  logic          busy;
  logic          err;

  mem_burst_resp #(.AN(AN), .DN(DN), .BURST(BURST)) dut (
    .clkSYS    (clkSYS),
    .aclr      (aclr),
    .request   (request),
    .req_addr  (req_addr),
    .req_ack   (req_ack),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_wait  (ram_wait),
    .ram_rdata (ram_rdata),
    .ram_rvalid(ram_rvalid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clkSYS = ~clkSYS;

  int cyc = 0;
  always @(posedge clkSYS) cyc <= cyc + 1;

  // ---------------- memory responder ----------------
  int wmode    = 0;   // 0: never stall, 1: random stall, 2: stall issue cycles 3..5
  int lat_lo   = 2;
  int lat_hi   = 2;
  int spur_gen = 0;   // bumped by the stimulus to request one stray return

  typedef struct {
    logic [AN-1:0] a;
    int            due;
  } rd_t;

  rd_t mq[$];
  int  spur_seen = 0;
  int  stall_n   = 0;

  always @(negedge clkSYS) begin
    if (aclr) begin
      mq.delete();
      ram_rvalid = 1'b0;
      ram_wait   = 1'b0;
      stall_n    = 0;
      spur_seen  = spur_gen;
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        ram_rvalid = 1'b1;
        ram_rdata  = mq[0].a[DN-1:0];
        void'(mq.pop_front());
      end else if (spur_seen != spur_gen) begin
        ram_rvalid = 1'b1;
        ram_rdata  = DN'($urandom);
        spur_seen  = spur_gen;
      end else begin
        ram_rvalid = 1'b0;
      end
      case (wmode)
        1: ram_wait = ($urandom_range(0, 3) == 0);
        2: begin
          if (ram_rd) stall_n++;
          else stall_n = 0;
          ram_wait = (stall_n >= 3 && stall_n <= 5);
        end
        default: ram_wait = 1'b0;
      endcase
      if (ram_rd && !ram_wait) begin
        rd_t r;
        r.a   = ram_addr;
        r.due = cyc + int'($urandom_range(lat_lo, lat_hi));
        mq.push_back(r);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int            n_checks    = 0;
  int            n_errs      = 0;
  logic [AN-1:0] exp_addr[$];
  logic [DN-1:0] exp_data[$];
  int            pending     = 0;
  int            rets        = 0;
  int            last_mv_cyc = -1;
  bit            mv_exp      = 1'b0;
  bit            err_exp     = 1'b0;
  bit            in_burst    = 1'b0;
  bit            prev_ack    = 1'b0;
  logic [DN-1:0] last_data   = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  always begin
    @(negedge clkSYS or posedge aclr);
    #1;
    if (aclr) begin
      chk("rst_req_ack",   32'(req_ack),   0);
      chk("rst_mem_valid", 32'(mem_valid), 0);
      chk("rst_ram_rd",    32'(ram_rd),    0);
      chk("rst_busy",      32'(busy),      0);
      chk("rst_err",       32'(err),       0);
      chk("rst_mem_data",  32'(mem_data),  0);
      chk("rst_ram_addr",  32'(ram_addr),  0);
      exp_addr.delete();
      exp_data.delete();
      pending     = 0;
      rets        = 0;
      last_mv_cyc = -1;
      mv_exp      = 1'b0;
      err_exp     = 1'b0;
      in_burst    = 1'b0;
      prev_ack    = 1'b0;
      last_data   = '0;
    end else begin
      chk("mem_valid", 32'(mem_valid), 32'(mv_exp));
      if (mem_valid && exp_data.size() > 0) begin
        logic [DN-1:0] d;
        d = exp_data.pop_front();
        chk("mem_data", 32'(mem_data), 32'(d));
        last_data   = d;
        rets++;
        last_mv_cyc = cyc;
      end else if (!mem_valid) begin
        chk("mem_data_hold", 32'(mem_data), 32'(last_data));
      end
      chk("err", 32'(err), 32'(err_exp));
      if (req_ack) begin
        chk("ack_pulse", 32'(prev_ack), 0);
        if (!prev_ack) begin
          chk("ack_prev_drained", 32'(exp_data.size()), 0);
          chk("ack_after_last_mv", 32'(cyc > last_mv_cyc), 1);
          for (int i = 0; i < BURST; i++) begin
            logic [AN-1:0] a;
            a = req_addr + AN'(i);
            exp_addr.push_back(a);
            exp_data.push_back(a[DN-1:0]);
          end
          in_burst = 1'b1;
          rets     = 0;
        end
      end
      prev_ack = req_ack;
      chk("busy", 32'(busy), 32'(in_burst));
      // a return can only answer a read accepted on an earlier edge
      mv_exp = ram_rvalid && (pending > 0);
      if (ram_rvalid) begin
        if (pending > 0) pending--;
        else err_exp = 1'b1;
      end
      if (ram_rd) begin
        if (exp_addr.size() == 0) begin
          chk("spurious_rd", 32'(ram_rd), 0);
        end else begin
          chk("rd_addr", 32'(ram_addr), 32'(exp_addr[0]));
        end
        if (!ram_wait) begin
          if (exp_addr.size() > 0) void'(exp_addr.pop_front());
          pending++;
        end
      end
      if (in_burst && rets == BURST) in_burst = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clkSYS);
    #2;
  endtask

  task automatic wait_ack(input logic [AN-1:0] a);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!req_ack && k < 60);
    if (!req_ack) begin
      $display("FAIL ack_timeout: no req_ack for addr 0x%0h after %0d cycles", a, k);
      $fatal(1, "request not acknowledged");
    end
  endtask

  task automatic do_burst(input logic [AN-1:0] a, input bit hold);
    int k;
    req_addr = a;
    request  = 1'b1;
    wait_ack(a);
    if (!hold) request = 1'b0;
    k = 0;
    while (in_burst && k < 400) begin
      tick();
      k++;
    end
    if (in_burst) begin
      $display("FAIL burst_timeout: burst at 0x%0h returned %0d of %0d words", a, rets, BURST);
      $fatal(1, "burst did not complete");
    end
  endtask

  initial begin
    int cnt;
    int k;
    logic [AN-1:0] ra;
    bit b2b;

    #2 aclr = 1'b1;
    repeat (3) tick();
    aclr = 1'b0;
    repeat (2) tick();

    // basic burst, fixed 2-cycle latency
    wmode = 0; lat_lo = 2; lat_hi = 2;
    do_burst(24'h000100, 1'b0);
    repeat (2) tick();

    // stall on the 3rd..5th issue cycles
    wmode = 2;
    do_burst(24'h000100, 1'b0);
    wmode = 0;
    repeat (2) tick();

    // wrap through the top of the address space
    do_burst(24'hFFFFFC, 1'b0);
    repeat (2) tick();

    // back-to-back with request held high
    do_burst(24'h000200, 1'b1);
    do_burst(24'h000200, 1'b0);
    repeat (2) tick();

    // reset after the 3rd returned word
    req_addr = 24'h000150;
    request  = 1'b1;
    wait_ack(24'h000150);
    request = 1'b0;
    cnt = 0;
    k   = 0;
    while (cnt < 3 && k < 200) begin
      tick();
      k++;
      if (mem_valid) cnt++;
    end
    if (cnt < 3) begin
      $display("FAIL mid_burst_timeout: saw %0d of 3 words", cnt);
      $fatal(1, "mid-burst wait expired");
    end
    aclr = 1'b1;
    repeat (3) tick();
    aclr = 1'b0;
    repeat (2) tick();
    do_burst(24'h000300, 1'b0);
    repeat (2) tick();

    // stray return while idle, then a good burst with err still set
    spur_gen++;
    repeat (4) tick();
    do_burst(24'h000180, 1'b0);
    repeat (2) tick();

    // randomized bursts with random stalls and latency
    wmode = 1; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 20; i++) begin
      ra  = AN'($urandom);
      b2b = ($urandom_range(0, 3) == 0);
      do_burst(ra, b2b);
      if (b2b) do_burst(ra, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    wmode = 0;

    // reset clears the sticky error
    tick();
    aclr = 1'b1;
    repeat (2) tick();
    aclr = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mem_burst_resp.md
MEM_BURST_RESP -- requirements
Module: mem_burst_resp

Interface
REQ-001 SHALL have parameter AN, default 24, address width.
REQ-002 SHALL have parameter DN, default 16, data width.
REQ-003 SHALL have parameter BURST, default 8, words returned per acknowledged request (power of two, 2..32).
REQ-004 SHALL have port clkSYS  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port aclr  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port request  in  1  burst read request from the requester.
REQ-007 SHALL have port req_addr  in  AN  burst start word address, valid while request=1.
REQ-008 SHALL have port req_ack  out  1  one-cycle acknowledge; start address accepted.
REQ-009 SHALL have port mem_data  out  DN  returned read word.
REQ-010 SHALL have port mem_valid  out  1  mem_data valid this cycle.
REQ-011 SHALL have port ram_addr  out  AN  memory read address.
REQ-012 SHALL have port ram_rd  out  1  memory read strobe; a read is accepted when ram_rd=1 and ram_wait=0.
REQ-013 SHALL have port ram_wait  in  1  memory stall; ram_addr and ram_rd are held while set.
REQ-014 SHALL have port ram_rdata  in  DN  memory read data.
REQ-015 SHALL have port ram_rvalid  in  1  ram_rdata valid; arrives in issue order, with any latency of 1 cycle or more.
REQ-016 SHALL have port busy  out  1  burst in progress.
REQ-017 SHALL have port err  out  1  sticky flag for unexpected ram_rvalid.

Function
REQ-018 SHALL implement the states IDLE, ACK, ISSUE and DRAIN.
REQ-019 IDLE with request=1 SHALL latch req_addr, go to ACK and drive req_ack=1 for exactly that one cycle (registered output, one cycle after request is sampled).
REQ-020 ACK SHALL always go to ISSUE on the next cycle; request SHALL be ignored in every state except IDLE.
REQ-021 ISSUE SHALL drive ram_rd=1 with ram_addr = start + i, for i = 0..BURST-1.
REQ-022 i SHALL advance only on accepted reads.
REQ-023 After the BURST-th accepted read, the block SHALL go to DRAIN with ram_rd=0.
REQ-024 Address arithmetic SHALL be modulo 2^AN; no alignment SHALL be required.
REQ-025 Each ram_rvalid SHALL produce mem_valid=1 with mem_data=ram_rdata one cycle later (registered), independent of ram_wait.
REQ-026 A return counter (width clog2(BURST)+1) SHALL count ram_rvalid pulses.
REQ-027 DRAIN SHALL go to IDLE in the cycle after the BURST-th return; at most one burst SHALL be outstanding.
REQ-028 If request=1 at IDLE re-entry, the next req_ack SHALL come no earlier than one cycle after the last mem_valid of the previous burst.
REQ-029 ram_rvalid in IDLE or ACK, or beyond BURST returns, SHALL be dropped (no mem_valid) and SHALL set err=1 until aclr.
REQ-030 busy SHALL be 1 in ACK, ISSUE and DRAIN, and 0 in IDLE.
REQ-031 mem_data SHALL hold its last value when mem_valid=0.

Reset
REQ-032 aclr=1 SHALL force, without waiting for a clock: state IDLE; req_ack, mem_valid, ram_rd, busy and err to 0; mem_data and ram_addr to 0; both counters to 0.
REQ-033 aclr mid-burst SHALL abandon the burst with no further reads issued; the first request after release SHALL be served as a fresh burst.

Structure
REQ-034 A shared package mem_pkg SHALL hold the state enum type and the default AN, DN and BURST constants.
REQ-035 The block SHALL be a single module with no sub-module; the issue and return counters SHALL be local.

Verification
REQ-036 Basic burst: BURST=8, ram_wait=0, memory returns data = addr[15:0] after 2 cycles, request with req_addr=0x000100 -> req_ack=1 for one cycle; ram_rd=1 on 8 consecutive cycles with addresses 0x000100..0x000107; mem_valid on 8 cycles with data 0x0100..0x0107; busy falls one cycle after the last mem_valid.
REQ-037 Stall: same stimulus with ram_wait=1 on the 3rd-5th issue cycles -> ram_addr holds 0x000102 during the stall; exactly 8 reads, none skipped or duplicated; 8 correct words returned.
REQ-038 Wrap: req_addr=0xFFFFFC -> addresses 0xFFFFFC..0xFFFFFF, then 0x000000..0x000003.
REQ-039 Back-to-back: request held at 1 with req_addr=0x000200 -> second req_ack strictly after the 8th mem_valid of the first burst; no ram_rd during ACK or DRAIN.
REQ-040 Reset mid-burst: aclr pulsed after the 3rd mem_valid -> all outputs 0 immediately; with no stale ram_rvalid driven, a new request at 0x000300 returns 8 words 0x0300..0x0307 and err=0.
REQ-041 Spurious return: ram_rvalid=1 while IDLE -> mem_valid stays 0; err=1 and stays 1 through later good bursts until aclr.
